// File: rtl/mem_write_scheduler.sv
// Write-port scheduler for video RAM: a CPU write FIFO and a fill engine share
// one memory-controller write port under round-robin arbitration, one write in flight.
module mem_write_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic        cpuWr,
  input  logic [15:0] cpuAddr,
  input  logic [7:0]  cpuData,
  output logic        cpuFull,
  output logic        overflow,
  input  logic        fillStart,
  input  logic [15:0] fillAddr,
  input  logic [15:0] fillLen,
  input  logic [7:0]  fillData,
  output logic        fillBusy,
  output logic        wrVga,
  output logic [15:0] aVga,
  output logic [7:0]  dVga,
  input  logic        wrVgaReq
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  state_t             state_q, state_d;
  wr_t                wr_q, wr_d;
  logic               wrVga_q, wrVga_d;
  logic               lastCpu_q, lastCpu_d;  // 0 = FILL got the last grant

  wr_t                fifo_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   cnt_q;
  logic               ovf_q;

  logic               fBusy_q;
  logic [15:0]        fAddr_q, fLen_q;
  logic [7:0]         fData_q;

  logic push, pop, fillAdv, cpuPend, fillPend, fillDone, fillGo;

  assign cpuFull  = (cnt_q == (FIFO_AW+1)'(FIFO_DEPTH));
  assign overflow = ovf_q;
  assign fillBusy = fBusy_q;
  assign wrVga    = wrVga_q;
  assign aVga     = wr_q.addr;
  assign dVga     = wr_q.data;

  // A full FIFO drops the push even if the arbiter pops in the same cycle.
  assign push     = cpuWr & ~cpuFull;
  assign cpuPend  = (cnt_q != '0);
  assign fillPend = fBusy_q & (fLen_q != 16'h0);
  assign fillGo   = fillStart & ~fBusy_q & (fillLen != 16'h0);
  assign fillDone = (state_q == S_WAIT) & wrVgaReq & ~lastCpu_q & fBusy_q & (fLen_q == 16'h0);

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    wrVga_d   = 1'b0;
    lastCpu_d = lastCpu_q;
    pop       = 1'b0;
    fillAdv   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpuPend || fillPend) begin
          if (fillPend && (!cpuPend || lastCpu_q)) begin
            fillAdv   = 1'b1;
            wr_d      = '{addr: fAddr_q, data: fData_q};
            lastCpu_d = 1'b0;
          end else begin
            pop       = 1'b1;
            wr_d      = fifo_q[rptr_q];
            lastCpu_d = 1'b1;
          end
          wrVga_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (wrVgaReq) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q   <= S_IDLE;
      wr_q      <= '0;
      wrVga_q   <= 1'b0;
      lastCpu_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      wrVga_q   <= wrVga_d;
      lastCpu_q <= lastCpu_d;
    end
  end

  // Storage needs no reset; only pointers and count define occupancy.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= '{addr: cpuAddr, data: cpuData};
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
      if (cpuWr && cpuFull) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      fBusy_q <= 1'b0;
      fAddr_q <= '0;
      fLen_q  <= '0;
      fData_q <= '0;
    end else if (fillGo) begin
      fBusy_q <= 1'b1;
      fAddr_q <= fillAddr;
      fLen_q  <= fillLen;
      fData_q <= fillData;
    end else begin
      if (fillAdv) begin
        fAddr_q <= fAddr_q + 16'h1;
        fLen_q  <= fLen_q - 16'h1;
      end
      if (fillDone) fBusy_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_write_scheduler.sv
// Directed bench for mem_write_scheduler with a simple memory-controller responder
// that logs every issued write and returns the end-of-slot strobe.
module tb_mem_write_scheduler;

  logic        clk = 1'b0;
  logic        nReset;
  logic        cpuWr;
  logic [15:0] cpuAddr;
  logic [7:0]  cpuData;
  logic        cpuFull, overflow;
  logic        fillStart;
  logic [15:0] fillAddr, fillLen;
  logic [7:0]  fillData;
  logic        fillBusy, wrVga;
  logic [15:0] aVga;
  logic [7:0]  dVga;
  logic        wrVgaReq;

  int tests = 0;
  int fails = 0;

  logic [23:0] wlog[$];
  int          respDly = 4;
  logic        respEn  = 1'b1;
  logic        stab_bad = 1'b0;
  int          reqCnt = 0;

  mem_write_scheduler #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .clk(clk), .nReset(nReset),
    .cpuWr(cpuWr), .cpuAddr(cpuAddr), .cpuData(cpuData),
    .cpuFull(cpuFull), .overflow(overflow),
    .fillStart(fillStart), .fillAddr(fillAddr), .fillLen(fillLen), .fillData(fillData),
    .fillBusy(fillBusy),
    .wrVga(wrVga), .aVga(aVga), .dVga(dVga), .wrVgaReq(wrVgaReq)
  );

  always #5 clk = ~clk;

  // Responder: log each issue, hold respDly clks (checking address/data hold), then strobe.
  initial begin
    logic [23:0] cap;
    wrVgaReq = 1'b0;
    forever begin
      @(negedge clk);
      if (wrVga === 1'b1) begin
        cap = {aVga, dVga};
        wlog.push_back(cap);
        for (int k = 0; k < respDly; k++) begin
          @(negedge clk);
          if ({aVga, dVga} !== cap) stab_bad = 1'b1;
        end
        while (!respEn) begin
          @(negedge clk);
          if ({aVga, dVga} !== cap) stab_bad = 1'b1;
        end
        wrVgaReq = 1'b1;
        reqCnt++;
        @(negedge clk);
        wrVgaReq = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_writes(input int n, input int budget, input string tag);
    int t = 0;
    while (wlog.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk(tag, wlog.size(), n);
  endtask

  task automatic do_reset();
    nReset = 1'b0; cpuWr = 1'b0; fillStart = 1'b0;
    tick(2);
    nReset = 1'b1;
    wlog.delete();
    reqCnt = 0; stab_bad = 1'b0; respEn = 1'b1;
    tick(1);
  endtask

  initial begin
    logic [15:0] exp5 [10];
    logic        reqAt;
    int          cntAt;
    logic        dropped;

    nReset = 1'b0; cpuWr = 1'b0; cpuAddr = '0; cpuData = '0;
    fillStart = 1'b0; fillAddr = '0; fillLen = '0; fillData = '0;

    // 1. reset with cpuWr asserted
    @(negedge clk);
    cpuWr = 1'b1; cpuAddr = 16'hFFFF; cpuData = 8'hFF;
    tick(3);
    chk("rst_wrVga", wrVga, 0);
    chk("rst_aVga", aVga, 0);
    chk("rst_dVga", dVga, 0);
    chk("rst_cpuFull", cpuFull, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_fillBusy", fillBusy, 0);
    cpuWr = 1'b0; nReset = 1'b1;
    tick(3);
    chk("rst_no_issue", wlog.size(), 0);

    // 2. single CPU write; issue two clks after the strobe
    do_reset();
    cpuWr = 1'b1; cpuAddr = 16'h1234; cpuData = 8'hA5;
    tick(1);
    cpuWr = 1'b0;
    tick(1);
    chk("single_issue_wrVga", wrVga, 1);
    chk("single_issue_aVga", aVga, 16'h1234);
    chk("single_issue_dVga", dVga, 8'hA5);
    wait_writes(1, 50, "single_wait");
    tick(12);
    chk("single_count", wlog.size(), 1);
    chk("single_hold", stab_bad, 0);
    chk("single_log", wlog[0], 24'h1234A5);

    // 3. FIFO overflow with the controller stalled
    do_reset();
    respEn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cpuWr = 1'b1; cpuAddr = 16'(i); cpuData = 8'(8'h10 + i);
      tick(1);
    end
    chk("ovf_not_full_4", cpuFull, 0);
    cpuAddr = 16'd4; cpuData = 8'h14;
    tick(1);
    chk("ovf_full_5", cpuFull, 1);
    chk("ovf_clear_5", overflow, 0);
    cpuAddr = 16'd5; cpuData = 8'h15;
    tick(1);
    cpuWr = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_still_full", cpuFull, 1);
    respEn = 1'b1;
    wait_writes(5, 200, "ovf_drain");
    tick(15);
    chk("ovf_count", wlog.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("ovf_order%0d", i), wlog[i], {16'(i), 8'(8'h10 + i)});
    chk("ovf_sticky", overflow, 1);
    chk("ovf_empty", cpuFull, 0);

    // 4. fill crossing the address wrap; busy drops on the 3rd end-of-slot
    do_reset();
    fillStart = 1'b1; fillAddr = 16'hFFFE; fillLen = 16'd3; fillData = 8'h00;
    tick(1);
    fillStart = 1'b0;
    chk("fill_busy_set", fillBusy, 1);
    dropped = 1'b0; reqAt = 1'b0; cntAt = 0;
    for (int t = 0; t < 200 && !dropped; t++) begin
      @(posedge clk);
      reqAt = wrVgaReq; cntAt = reqCnt;
      #1;
      if (fillBusy !== 1'b1) dropped = 1'b1;
    end
    chk("fill_busy_dropped", dropped, 1);
    chk("fill_drop_on_req", reqAt, 1);
    chk("fill_drop_req_cnt", cntAt, 3);
    tick(10);
    chk("fill_count", wlog.size(), 3);
    chk("fill_w0", wlog[0], 24'hFFFE00);
    chk("fill_w1", wlog[1], 24'hFFFF00);
    chk("fill_w2", wlog[2], 24'h000000);

    // 5. contention: CPU wins the first tie after reset, then alternation
    do_reset();
    cpuWr = 1'b1; cpuAddr = 16'h0200; cpuData = 8'h11;
    fillStart = 1'b1; fillAddr = 16'h0100; fillLen = 16'd8; fillData = 8'h5A;
    tick(1);
    fillStart = 1'b0; cpuAddr = 16'h0201; cpuData = 8'h22;
    tick(1);
    cpuWr = 1'b0;
    exp5 = '{16'h0200, 16'h0100, 16'h0201, 16'h0101, 16'h0102,
             16'h0103, 16'h0104, 16'h0105, 16'h0106, 16'h0107};
    wait_writes(10, 400, "cont_wait");
    tick(12);
    chk("cont_count", wlog.size(), 10);
    for (int i = 0; i < 10; i++) chk($sformatf("cont_addr%0d", i), wlog[i][23:8], exp5[i]);
    chk("cont_d0", wlog[0][7:0], 8'h11);
    chk("cont_d1", wlog[1][7:0], 8'h5A);
    chk("cont_d2", wlog[2][7:0], 8'h22);
    chk("cont_hold", stab_bad, 0);
    chk("cont_idle_busy", fillBusy, 0);

    // 6. zero-length fill, then a start while busy
    do_reset();
    fillStart = 1'b1; fillAddr = 16'h3000; fillLen = 16'd0; fillData = 8'hEE;
    tick(1);
    fillStart = 1'b0;
    tick(8);
    chk("edge_len0_writes", wlog.size(), 0);
    chk("edge_len0_busy", fillBusy, 0);
    fillStart = 1'b1; fillAddr = 16'h4000; fillLen = 16'd2; fillData = 8'h77;
    tick(1);
    fillStart = 1'b0;
    tick(1);
    chk("edge_busy_before", fillBusy, 1);
    fillStart = 1'b1; fillAddr = 16'h5000; fillLen = 16'd5; fillData = 8'h88;
    tick(1);
    fillStart = 1'b0;
    wait_writes(2, 200, "edge_wait");
    tick(20);
    chk("edge_count", wlog.size(), 2);
    chk("edge_w0", wlog[0], 24'h400077);
    chk("edge_w1", wlog[1], 24'h400177);
    chk("edge_busy_after", fillBusy, 0);

    // 7. reset while waiting on the controller
    do_reset();
    respEn = 1'b0;
    fillStart = 1'b1; fillAddr = 16'h6000; fillLen = 16'd4; fillData = 8'hC3;
    tick(1);
    fillStart = 1'b0;
    wait_writes(1, 50, "mid_first");
    tick(2);
    nReset = 1'b0;
    tick(1);
    chk("mid_wrVga", wrVga, 0);
    chk("mid_busy", fillBusy, 0);
    chk("mid_aVga", aVga, 0);
    nReset = 1'b1;
    respEn = 1'b1;
    tick(30);
    chk("mid_no_more", wlog.size(), 1);
    chk("mid_busy_after", fillBusy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
